// File: rtl/preif_pc_gen_if.sv
// Fetch PC generator bus: stall/redirect/prediction inputs and the registered fetch request.
// master = pipeline side driving the generator, slave = the PC generator itself.
interface preif_pc_gen_if;
    logic        PREIF_Wr;
    logic        Exc_Redirect;
    logic [31:0] Exc_Target;
    logic        EXE_Redirect;
    logic [31:0] EXE_Target;
    logic        BPU_Valid;
    logic        BPU_Taken;
    logic [31:0] BPU_Target;
    logic [31:0] PREIF_PC;
    logic        PREIF_Valid;
    logic        IF_Flush;
    logic        PC_Misalign;

    modport master (
        output PREIF_Wr, Exc_Redirect, Exc_Target, EXE_Redirect, EXE_Target,
        output BPU_Valid, BPU_Taken, BPU_Target,
        input  PREIF_PC, PREIF_Valid, IF_Flush, PC_Misalign
    );

    modport slave (
        input  PREIF_Wr, Exc_Redirect, Exc_Target, EXE_Redirect, EXE_Target,
        input  BPU_Valid, BPU_Taken, BPU_Target,
        output PREIF_PC, PREIF_Valid, IF_Flush, PC_Misalign
    );
endinterface

// File: rtl/preif_pc_gen.sv
// Pre-IF fetch PC generator: redirect priority, stall-time redirect latching, forced exception.
// Define PREIF_PCGEN_BPU_EN to let taken branch predictions steer the sequential path.
module preif_pc_gen #(
    parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
    parameter int unsigned EXC_HOLD_MAX = 4
) (
    input logic           clk,
    input logic           rst,
    preif_pc_gen_if.slave bus
);

    localparam int unsigned HoldW = (EXC_HOLD_MAX < 2) ? 1 : $clog2(EXC_HOLD_MAX + 1);

    typedef enum logic [1:0] {StRun, StPendExe, StPendExc} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [31:0]      sel_pc;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             warm_q, valid_q;
    logic             flush_q, flush_d;
    logic             sel_redir;
    logic             hold_hit;
    logic             load;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            hold_q  <= '0;
            warm_q  <= 1'b0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            warm_q  <= 1'b1;
            valid_q <= warm_q;
            flush_q <= flush_d;
        end
    end

    // Candidate next PC; a latched exception outranks a live EXE redirect
    always_comb begin
        sel_redir = 1'b1;
        sel_pc    = pc_q + 32'd4;
        if (bus.Exc_Redirect) begin
            sel_pc = bus.Exc_Target;
        end else if (state_q == StPendExc) begin
            sel_pc = tgt_q;
        end else if (bus.EXE_Redirect) begin
            sel_pc = bus.EXE_Target;
        end else if (state_q == StPendExe) begin
            sel_pc = tgt_q;
        end else begin
            sel_redir = 1'b0;
`ifdef PREIF_PCGEN_BPU_EN
            if (bus.BPU_Valid && bus.BPU_Taken) begin
                sel_pc = bus.BPU_Target;
            end
`endif
        end
    end

`ifndef PREIF_PCGEN_BPU_EN
    logic unused_bpu;
    assign unused_bpu = ^{bus.BPU_Valid, bus.BPU_Taken, bus.BPU_Target};
`endif

    assign hold_hit = (state_q == StPendExc) && ((32'(hold_q) + 32'd1) >= EXC_HOLD_MAX);
    assign load     = bus.PREIF_Wr || hold_hit;

    // Next state and datapath
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        hold_d  = '0;
        flush_d = 1'b0;
        if (load) begin
            pc_d    = sel_pc;
            flush_d = sel_redir;
            state_d = StRun;
        end else begin
            // Stalled: keep the PC, latch the winning redirect
            if (state_q == StPendExc) begin
                hold_d = hold_q + HoldW'(1);
            end
            if (bus.Exc_Redirect) begin
                tgt_d   = bus.Exc_Target;
                state_d = StPendExc;
            end else if (bus.EXE_Redirect && (state_q != StPendExc)) begin
                tgt_d   = bus.EXE_Target;
                state_d = StPendExe;
            end
        end
    end

    // Outputs
    always_comb begin
        bus.PREIF_PC    = pc_q;
        bus.PREIF_Valid = valid_q;
        bus.IF_Flush    = flush_q;
        bus.PC_Misalign = |pc_q[1:0];
    end

endmodule

// File: tb/tb_preif_pc_gen.sv
// Directed self-checking bench for preif_pc_gen: reset, sequencing, redirects, stalls, wrap.
module tb_preif_pc_gen;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    preif_pc_gen_if bus ();

    preif_pc_gen #(
        .RESET_PC    (32'hBFC0_0000),
        .EXC_HOLD_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.PREIF_Wr = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL reset_pc: got %h want bfc00000", bus.PREIF_PC);
        end
        n_checks++;
        if (bus.PREIF_Valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", bus.PREIF_Valid);
        end
        n_checks++;
        if (bus.IF_Flush !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush: got %b want 0", bus.IF_Flush);
        end
        n_checks++;
        if (bus.PC_Misalign !== 1'b0) begin
            n_fail++; $display("FAIL reset_misalign: got %b want 0", bus.PC_Misalign);
        end
    endtask

    task automatic test_sequential();
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0004) begin
            n_fail++; $display("FAIL seq_pc1: got %h want bfc00004", bus.PREIF_PC);
        end
        n_checks++;
        if (bus.PREIF_Valid !== 1'b0) begin
            n_fail++; $display("FAIL seq_valid1: got %b want 0", bus.PREIF_Valid);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0008) begin
            n_fail++; $display("FAIL seq_pc2: got %h want bfc00008", bus.PREIF_PC);
        end
        n_checks++;
        if (bus.PREIF_Valid !== 1'b1) begin
            n_fail++; $display("FAIL seq_valid2: got %b want 1", bus.PREIF_Valid);
        end
    endtask

    task automatic test_exe_stall();
        bus.PREIF_Wr     = 1'b0;
        bus.EXE_Redirect = 1'b1;
        bus.EXE_Target   = 32'h8000_0100;
        tick();
        bus.EXE_Redirect = 1'b0;
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0008 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exe_latch: pc %h flush %b want bfc00008 0", bus.PREIF_PC, bus.IF_Flush);
        end
        tick();
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0008 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exe_hold: pc %h flush %b want bfc00008 0", bus.PREIF_PC, bus.IF_Flush);
        end
        bus.PREIF_Wr = 1'b1;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0100 || bus.IF_Flush !== 1'b1) begin
            n_fail++;
            $display("FAIL exe_apply: pc %h flush %b want 80000100 1", bus.PREIF_PC, bus.IF_Flush);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0104 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exe_after: pc %h flush %b want 80000104 0", bus.PREIF_PC, bus.IF_Flush);
        end
    endtask

    task automatic test_exc_vs_exe();
        bus.Exc_Redirect = 1'b1;
        bus.Exc_Target   = 32'h8000_0180;
        bus.EXE_Redirect = 1'b1;
        bus.EXE_Target   = 32'h8000_0200;
        tick();
        bus.Exc_Redirect = 1'b0;
        bus.EXE_Redirect = 1'b0;
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0180 || bus.IF_Flush !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_prio: pc %h flush %b want 80000180 1", bus.PREIF_PC, bus.IF_Flush);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0184 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exe_dropped: pc %h flush %b want 80000184 0", bus.PREIF_PC, bus.IF_Flush);
        end
    endtask

    task automatic test_exc_hold();
        bus.PREIF_Wr     = 1'b0;
        bus.Exc_Redirect = 1'b1;
        bus.Exc_Target   = 32'h8000_0300;
        tick();
        bus.Exc_Redirect = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0184 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_held: pc %h flush %b want 80000184 0", bus.PREIF_PC, bus.IF_Flush);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0300 || bus.IF_Flush !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_forced: pc %h flush %b want 80000300 1", bus.PREIF_PC, bus.IF_Flush);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0300 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_post: pc %h flush %b want 80000300 0", bus.PREIF_PC, bus.IF_Flush);
        end
    endtask

    task automatic test_pend_overwrite();
        bus.PREIF_Wr     = 1'b0;
        bus.EXE_Redirect = 1'b1;
        bus.EXE_Target   = 32'h8000_0400;
        tick();
        bus.EXE_Target   = 32'h8000_0500;
        tick();
        bus.Exc_Redirect = 1'b1;
        bus.Exc_Target   = 32'h8000_0600;
        bus.EXE_Target   = 32'h8000_0700;
        tick();
        bus.Exc_Redirect = 1'b0;
        bus.EXE_Target   = 32'h8000_0800;
        tick();
        bus.EXE_Redirect = 1'b0;
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0300 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_hold: pc %h flush %b want 80000300 0", bus.PREIF_PC, bus.IF_Flush);
        end
        bus.PREIF_Wr = 1'b1;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0600 || bus.IF_Flush !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_apply: pc %h flush %b want 80000600 1", bus.PREIF_PC, bus.IF_Flush);
        end
    endtask

    task automatic test_bpu();
        logic [31:0] exp_pc;
`ifdef PREIF_PCGEN_BPU_EN
        exp_pc = 32'h8000_0040;
`else
        exp_pc = 32'h8000_0604;
`endif
        bus.BPU_Valid  = 1'b1;
        bus.BPU_Taken  = 1'b1;
        bus.BPU_Target = 32'h8000_0040;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== exp_pc || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL bpu_taken: pc %h flush %b want %h 0", bus.PREIF_PC, bus.IF_Flush, exp_pc);
        end
        bus.EXE_Redirect = 1'b1;
        bus.EXE_Target   = 32'h8000_0A00;
        tick();
        bus.EXE_Redirect = 1'b0;
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0A00 || bus.IF_Flush !== 1'b1) begin
            n_fail++;
            $display("FAIL bpu_vs_exe: pc %h flush %b want 80000a00 1", bus.PREIF_PC, bus.IF_Flush);
        end
        bus.BPU_Taken = 1'b0;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0A04) begin
            n_fail++; $display("FAIL bpu_not_taken: pc %h want 80000a04", bus.PREIF_PC);
        end
        bus.BPU_Valid = 1'b0;
    endtask

    task automatic test_wrap_misalign();
        bus.Exc_Redirect = 1'b1;
        bus.Exc_Target   = 32'hFFFF_FFFC;
        tick();
        bus.Exc_Redirect = 1'b0;
        n_checks++;
        if (bus.PREIF_PC !== 32'hFFFF_FFFC || bus.PC_Misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_load: pc %h mis %b want fffffffc 0", bus.PREIF_PC, bus.PC_Misalign);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap: pc %h want 00000000", bus.PREIF_PC);
        end
        bus.Exc_Redirect = 1'b1;
        bus.Exc_Target   = 32'h8000_0182;
        tick();
        bus.Exc_Redirect = 1'b0;
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0182 || bus.PC_Misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign: pc %h mis %b want 80000182 1", bus.PREIF_PC, bus.PC_Misalign);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'h8000_0186 || bus.PC_Misalign !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_seq: pc %h mis %b want 80000186 1", bus.PREIF_PC, bus.PC_Misalign);
        end
    endtask

    task automatic test_reset_mid_pend();
        bus.PREIF_Wr     = 1'b0;
        bus.EXE_Redirect = 1'b1;
        bus.EXE_Target   = 32'h8000_0900;
        tick();
        bus.EXE_Redirect = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0000 || bus.PREIF_Valid !== 1'b0 || bus.IF_Flush !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pend: pc %h valid %b flush %b want bfc00000 0 0",
                     bus.PREIF_PC, bus.PREIF_Valid, bus.IF_Flush);
        end
        rst = 1'b1;
        bus.PREIF_Wr = 1'b1;
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0004 || bus.IF_Flush !== 1'b0 || bus.PREIF_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_discard: pc %h flush %b valid %b want bfc00004 0 0",
                     bus.PREIF_PC, bus.IF_Flush, bus.PREIF_Valid);
        end
        tick();
        n_checks++;
        if (bus.PREIF_PC !== 32'hBFC0_0008 || bus.PREIF_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_resume: pc %h valid %b want bfc00008 1", bus.PREIF_PC, bus.PREIF_Valid);
        end
    endtask

    initial begin
        clk              = 1'b0;
        rst              = 1'b0;
        n_checks         = 0;
        n_fail           = 0;
        bus.PREIF_Wr     = 1'b0;
        bus.Exc_Redirect = 1'b0;
        bus.Exc_Target   = '0;
        bus.EXE_Redirect = 1'b0;
        bus.EXE_Target   = '0;
        bus.BPU_Valid    = 1'b0;
        bus.BPU_Taken    = 1'b0;
        bus.BPU_Target   = '0;

        test_reset();
        test_sequential();
        test_exe_stall();
        test_exc_vs_exe();
        test_exc_hold();
        test_pend_overwrite();
        test_bpu();
        test_wrap_misalign();
        test_reset_mid_pend();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
